vector_skid_register: RTL and testbench
=======================================

Name: vector_skid_register

Overview:
- Parametrised successor to the plain vector pipeline flip-flop.
- Registers an N-lane vector between pipeline stages of the vector processor, using a valid/ready handshake and a two-entry skid buffer.
- Supports per-lane write masking, so unmasked lanes merge with the previously accepted vector.
- Supports synchronous flush.
- Fully registered: no combinational in-to-out or out_ready-to-in_ready path.

Parameters:
- WIDTH, 24, bits per lane.
- VECTOR_WIDTH, 8, number of lanes (>=1).

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- flush  input  1  synchronous discard of all buffered entries.
- in_valid  input  1  producer offers a vector.
- in_ready  output  1  block can accept a vector this cycle.
- in_mask  input  VECTOR_WIDTH  per-lane write enable; bit i controls lane i.
- in_data  input  VECTOR_WIDTH x WIDTH  packed lanes, lane i = in_data[i].
- out_valid  output  1  out_data holds a valid vector.
- out_ready  input  1  consumer accepts out_data this cycle.
- out_data  output  VECTOR_WIDTH x WIDTH  head vector.
- count  output  2  entries held (0..2).

Behaviour:
- Storage: main register (head, drives out_data), skid register, shadow register (last accepted merged vector).
- Reset (reset=0, async):
  - out_valid=0, out_data=0, count=0, in_ready=1.
  - Skid and shadow cleared to 0; state EMPTY.
- Handshakes:
  - Accept = in_valid & in_ready.
  - Pop = out_valid & out_ready.
  - Both evaluated on the same edge.
- Merge on accept: lane i stored = in_mask[i] ? in_data[i] : shadow[i]. Shadow <= merged vector. Mask 0 on all lanes re-issues the shadow vector.
- States and transitions:
  - EMPTY (count 0):
    - accept -> ONE; merged vector into main.
  - ONE (count 1):
    - accept & pop -> ONE; main <= merged.
    - accept only -> FULL; merged into skid.
    - pop only -> EMPTY.
  - FULL (count 2):
    - in_ready=0, so no accept.
    - pop -> ONE; main <= skid.
- Output and ready rules:
  - out_valid = (state != EMPTY).
  - in_ready = (state != FULL), registered; never depends combinationally on out_ready.
  - out_data holds its value while out_valid & !out_ready (stable under backpressure).
- Latency: a vector accepted at edge N is visible on out_data after edge N when the block was EMPTY, or when it was ONE and popped on the same edge. Throughput is 1 vector per cycle with out_ready held high.
- FIFO order is strict: the skid entry never overtakes main.
- Flush:
  - Takes priority over accept and pop on the same edge.
  - Next state EMPTY, count=0, in_ready=1, out_valid=0.
  - A vector offered in the flush cycle is dropped and the shadow is not updated.
  - Shadow otherwise keeps its value.
  - out_data is don't-care while out_valid=0; implementation holds the old value.
- Reset mid-transfer: immediate return to reset values; in-flight data is lost.
- Widths: pure storage, no arithmetic. count is 2 bits and never exceeds 2.

Optional Feature:
- Macro: VECTOR_SKID_LANE_REVERSE_EN.
- Defined: out_data lane i = stored lane (VECTOR_WIDTH-1-i). This is a reversed lane order for consumers indexing from the top. in_mask/in_data indexing and the shadow are unaffected.
- Undefined: out_data lane i = stored lane i.

Test Plan:
- Reset then release, default params:
  - Expect out_valid=0, in_ready=1, count=0, out_data=0.
  - in_valid=1, in_mask=8'hFF, lanes=24'h000001..24'h000008 -> next cycle out_valid=1, lane0=24'h000001, count=1.
- Streaming, out_ready=1, four back-to-back full-mask vectors A,B,C,D -> out_data shows A,B,C,D on consecutive cycles, in_ready stays 1, count stays 1.
- Backpressure:
  - out_ready=0, offer A then B -> count=2, in_ready=0, C held off, out_data=A stable.
  - Raise out_ready -> A then B emitted; C accepted once in_ready=1.
- Masked merge:
  - Accept A (all lanes 24'hAAAAAA, mask FF), then B (all lanes 24'hBBBBBB, mask 8'h0F).
  - Expect second output lanes0-3=24'hBBBBBB, lanes4-7=24'hAAAAAA.
- Flush in FULL with in_valid=1 -> next cycle count=0, out_valid=0, in_ready=1.
  - Next accept with mask 00 -> out_data equals last pre-flush merged vector.
- Async reset asserted mid-cycle while FULL -> outputs go to reset values without a clock edge.
- With VECTOR_SKID_LANE_REVERSE_EN defined: first scenario gives out lane0=24'h000008, lane7=24'h000001.

Source files
------------

// File: rtl/vector_skid_register.sv
// N-lane vector pipeline register with a valid/ready handshake, a two-entry skid buffer,
// per-lane write masking against the last accepted vector, and synchronous flush.
// Optional build macro VECTOR_SKID_LANE_REVERSE_EN presents out_data with its lane order reversed.
module vector_skid_register #(
   parameter int WIDTH        = 24,
   parameter int VECTOR_WIDTH = 8
) (
   input  logic                                  clk,
   input  logic                                  reset,
   input  logic                                  flush,
   input  logic                                  in_valid,
   output logic                                  in_ready,
   input  logic [VECTOR_WIDTH-1:0]               in_mask,
   input  logic [VECTOR_WIDTH-1:0][WIDTH-1:0]    in_data,
   output logic                                  out_valid,
   input  logic                                  out_ready,
   output logic [VECTOR_WIDTH-1:0][WIDTH-1:0]    out_data,
   output logic [1:0]                            count
);

   // The state encoding doubles as the occupancy count.
   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_FULL  = 2'd2
   } state_t;

   state_t                               state_q, state_d;
   logic [VECTOR_WIDTH-1:0][WIDTH-1:0]   main_q, main_d;
   logic [VECTOR_WIDTH-1:0][WIDTH-1:0]   skid_q, skid_d;
   logic [VECTOR_WIDTH-1:0][WIDTH-1:0]   shadow_q, shadow_d;
   logic                                 in_ready_q, in_ready_d;

   logic [VECTOR_WIDTH-1:0][WIDTH-1:0]   merged;
   logic                                 accept;
   logic                                 pop;

   // Lanes whose mask bit is clear re-use the previously accepted vector.
   generate
      for (genvar gi = 0; gi < VECTOR_WIDTH; gi++) begin : g_merge
         assign merged[gi] = in_mask[gi] ? in_data[gi] : shadow_q[gi];
      end
   endgenerate

   assign out_valid = (state_q != ST_EMPTY);
   assign in_ready  = in_ready_q;
   assign count     = state_q;
   assign accept    = in_valid & in_ready_q;
   assign pop       = out_valid & out_ready;

   always_comb begin
      state_d  = state_q;
      main_d   = main_q;
      skid_d   = skid_q;
      shadow_d = shadow_q;

      if (flush) begin
         state_d = ST_EMPTY;
      end else begin
         if (accept) begin
            shadow_d = merged;
         end
         case (state_q)
            ST_EMPTY: begin
               if (accept) begin
                  main_d  = merged;
                  state_d = ST_ONE;
               end
            end
            ST_ONE: begin
               if (accept && pop) begin
                  main_d = merged;
               end else if (accept) begin
                  skid_d  = merged;
                  state_d = ST_FULL;
               end else if (pop) begin
                  state_d = ST_EMPTY;
               end
            end
            ST_FULL: begin
               if (pop) begin
                  main_d  = skid_q;
                  state_d = ST_ONE;
               end
            end
            default: begin
               state_d = ST_EMPTY;
            end
         endcase
      end

      // Ready is a flop so out_ready never reaches in_ready combinationally.
      in_ready_d = (state_d != ST_FULL);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= ST_EMPTY;
         main_q     <= '0;
         skid_q     <= '0;
         shadow_q   <= '0;
         in_ready_q <= 1'b1;
      end else begin
         state_q    <= state_d;
         main_q     <= main_d;
         skid_q     <= skid_d;
         shadow_q   <= shadow_d;
         in_ready_q <= in_ready_d;
      end
   end

   generate
      for (genvar gi = 0; gi < VECTOR_WIDTH; gi++) begin : g_out
`ifdef VECTOR_SKID_LANE_REVERSE_EN
         assign out_data[gi] = main_q[VECTOR_WIDTH-1-gi];
`else
         assign out_data[gi] = main_q[gi];
`endif
      end
   endgenerate

endmodule

// File: tb/tb_vector_skid_register.sv
// Directed bench for vector_skid_register: reset, streaming, backpressure, masked merge,
// flush and asynchronous reset, with hand-computed expected vectors.
module tb_vector_skid_register;

   localparam int W  = 24;
   localparam int VW = 8;

   typedef logic [VW-1:0][W-1:0] vec_t;

   logic       clk = 1'b0;
   logic       reset;
   logic       flush;
   logic       in_valid;
   logic       in_ready;
   logic [VW-1:0] in_mask;
   vec_t       in_data;
   logic       out_valid;
   logic       out_ready;
   vec_t       out_data;
   logic [1:0] count;

   int checks   = 0;
   int failures = 0;

   vector_skid_register #(.WIDTH(W), .VECTOR_WIDTH(VW)) dut (
      .clk       (clk),
      .reset     (reset),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_mask   (in_mask),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .count     (count)
   );

   always #5 clk = ~clk;

   // Expected view of a stored vector on out_data.
   function automatic vec_t view(input vec_t s);
      vec_t r;
      for (int i = 0; i < VW; i++) begin
`ifdef VECTOR_SKID_LANE_REVERSE_EN
         r[i] = s[VW-1-i];
`else
         r[i] = s[i];
`endif
      end
      return r;
   endfunction

   function automatic vec_t ramp(input logic [W-1:0] base);
      vec_t r;
      for (int i = 0; i < VW; i++) r[i] = base + W'(i);
      return r;
   endfunction

   function automatic vec_t fill(input logic [W-1:0] v);
      vec_t r;
      for (int i = 0; i < VW; i++) r[i] = v;
      return r;
   endfunction

   task automatic chk(input string tag, input logic [VW*W-1:0] obs, input logic [VW*W-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic status(input string tag, input logic v, input logic r, input logic [1:0] c);
      chk({tag, ".out_valid"}, VW*W'(out_valid), VW*W'(v));
      chk({tag, ".in_ready"},  VW*W'(in_ready),  VW*W'(r));
      chk({tag, ".count"},     VW*W'(count),     VW*W'(c));
   endtask

   task automatic offer(input vec_t d, input logic [VW-1:0] m);
      in_valid = 1'b1;
      in_data  = d;
      in_mask  = m;
   endtask

   vec_t va, vb, vc, vd, m_exp, x1, x2, x3, lane_first;

   initial begin
      reset     = 1'b0;
      flush     = 1'b0;
      in_valid  = 1'b0;
      in_mask   = '0;
      in_data   = '0;
      out_ready = 1'b0;

      // Reset state
      #12;
      status("reset", 1'b0, 1'b1, 2'd0);
      chk("reset.out_data", out_data, '0);
      reset = 1'b1;
      #1;

      // First vector, lanes 1..8
      offer(ramp(24'h000001), 8'hFF);
      step();
      status("first", 1'b1, 1'b1, 2'd1);
      chk("first.out_data", out_data, view(ramp(24'h000001)));
      lane_first = view(ramp(24'h000001));
      chk("first.lane0", VW*W'(out_data[0]), VW*W'(lane_first[0]));
      in_valid  = 1'b0;
      out_ready = 1'b1;
      step();
      status("drain1", 1'b0, 1'b1, 2'd0);

      // Streaming with out_ready held high
      va = ramp(24'h0A0000);
      vb = ramp(24'h0B0000);
      vc = ramp(24'h0C0000);
      vd = ramp(24'h0D0000);
      offer(va, 8'hFF); step(); status("strA", 1'b1, 1'b1, 2'd1); chk("strA.data", out_data, view(va));
      offer(vb, 8'hFF); step(); status("strB", 1'b1, 1'b1, 2'd1); chk("strB.data", out_data, view(vb));
      offer(vc, 8'hFF); step(); status("strC", 1'b1, 1'b1, 2'd1); chk("strC.data", out_data, view(vc));
      offer(vd, 8'hFF); step(); status("strD", 1'b1, 1'b1, 2'd1); chk("strD.data", out_data, view(vd));
      in_valid = 1'b0;
      step();
      status("strEnd", 1'b0, 1'b1, 2'd0);

      // Backpressure fills the skid, then drains in order
      out_ready = 1'b0;
      offer(va, 8'hFF); step(); status("bpA", 1'b1, 1'b1, 2'd1); chk("bpA.data", out_data, view(va));
      offer(vb, 8'hFF); step(); status("bpB", 1'b1, 1'b0, 2'd2); chk("bpB.data", out_data, view(va));
      offer(vc, 8'hFF); step(); status("bpHold", 1'b1, 1'b0, 2'd2); chk("bpHold.data", out_data, view(va));
      out_ready = 1'b1;
      step(); status("bpPopA", 1'b1, 1'b1, 2'd1); chk("bpPopA.data", out_data, view(vb));
      step(); status("bpAccC", 1'b1, 1'b1, 2'd1); chk("bpAccC.data", out_data, view(vc));
      in_valid = 1'b0;
      step(); status("bpEnd", 1'b0, 1'b1, 2'd0);

      // Masked merge against the previous vector
      offer(fill(24'hAAAAAA), 8'hFF); step();
      chk("mergeA.data", out_data, view(fill(24'hAAAAAA)));
      offer(fill(24'hBBBBBB), 8'h0F); step();
      m_exp = fill(24'hAAAAAA);
      for (int i = 0; i < 4; i++) m_exp[i] = 24'hBBBBBB;
      status("mergeB", 1'b1, 1'b1, 2'd1);
      chk("mergeB.data", out_data, view(m_exp));
      in_valid = 1'b0;
      step();

      // Flush while full with a vector offered; shadow keeps the last pre-flush merge
      x1 = ramp(24'h000100);
      x2 = ramp(24'h000200);
      x3 = ramp(24'h000300);
      out_ready = 1'b0;
      offer(x1, 8'hFF); step();
      offer(x2, 8'hFF); step(); status("preFlush", 1'b1, 1'b0, 2'd2);
      offer(x3, 8'hFF);
      flush = 1'b1;
      step();
      flush = 1'b0;
      status("flush", 1'b0, 1'b1, 2'd0);
      chk("flush.hold", out_data, view(x1));
      offer(fill(24'hFFFFFF), 8'h00); step();
      status("postFlush", 1'b1, 1'b1, 2'd1);
      chk("postFlush.data", out_data, view(x2));

      // Async reset while full, no clock edge involved
      offer(x3, 8'hFF); step();
      in_valid = 1'b0;
      status("preRst", 1'b1, 1'b0, 2'd2);
      #2;
      reset = 1'b0;
      #1;
      status("asyncRst", 1'b0, 1'b1, 2'd0);
      chk("asyncRst.data", out_data, '0);
      #1;
      reset = 1'b1;
      // Shadow was cleared: an all-masked vector re-issues zeros
      offer(fill(24'h123456), 8'h00); step();
      status("rstShadow", 1'b1, 1'b1, 2'd1);
      chk("rstShadow.data", out_data, '0);
      in_valid = 1'b0;
      step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
